// File: rtl/mega_jsoc_sysid_checker_pkg.sv
// Shared FSM state type, word-address constants and default expected values
// for the sysid checker and its wait timer.
package mega_jsoc_sysid_checker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_ID  = 2'd1,
        RD_TS  = 2'd2,
        FINISH = 2'd3
    } state_e;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'd30;
    localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1718298719;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES     = 255;

endpackage

// File: rtl/mega_jsoc_sysid_checker_if.sv
// Avalon-MM read-only link between the checker (master) and a sysid responder (slave).
interface mega_jsoc_sysid_checker_if;

    logic        av_address;
    logic        av_read;
    logic [31:0] av_readdata;
    logic        av_waitrequest;

    modport master (
        output av_address,
        output av_read,
        input  av_readdata,
        input  av_waitrequest
    );

    modport slave (
        input  av_address,
        input  av_read,
        output av_readdata,
        output av_waitrequest
    );

endinterface

// File: rtl/mega_jsoc_sysid_wait_timer.sv
// Watchdog for a stalled Avalon read: counts consecutive waitrequest cycles and
// flags the cycle on which the count reaches TIMEOUT_CYCLES.
module mega_jsoc_sysid_wait_timer
    import mega_jsoc_sysid_checker_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clock,
    input  logic reset_n,
    input  logic stalled,
    output logic expired
);

    localparam logic [15:0] TERMINAL_COUNT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // Any non-stalled cycle (a completed read or no read at all) restarts the run.
    always_comb begin
        count_d = 16'd0;
        if (stalled) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = stalled && (count_q == TERMINAL_COUNT);

endmodule

// File: rtl/mega_jsoc_sysid_checker.sv
// Reads sysid words 0 (ID) and 1 (timestamp) over Avalon-MM and compares them with
// the expected values. Optional watchdog enabled by macro SYSID_CHECK_TIMEOUT_EN.
module mega_jsoc_sysid_checker
    import mega_jsoc_sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
    parameter int unsigned TIMEOUT_CYCLES     = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    mega_jsoc_sysid_checker_if.master av,
    output logic                      busy,
    output logic                      done,
    output logic                      id_ok,
    output logic                      ts_ok,
    output logic                      pass,
    output logic                      timeout,
    output logic [31:0]               id_value,
    output logic [31:0]               ts_value
);

    generate
        if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must lie in 1..65535");
        end
    endgenerate

    state_e      state_q;
    state_e      state_d;
    logic        av_read_q;
    logic        av_read_d;
    logic        av_address_q;
    logic        av_address_d;
    logic        id_ok_q;
    logic        id_ok_d;
    logic        ts_ok_q;
    logic        ts_ok_d;
    logic        timeout_q;
    logic        timeout_d;
    logic [31:0] id_value_q;
    logic [31:0] id_value_d;
    logic [31:0] ts_value_q;
    logic [31:0] ts_value_d;

    logic stalled;
    logic rd_done;
    logic wait_expired;

    assign stalled = av_read_q &  av.av_waitrequest;
    assign rd_done = av_read_q & ~av.av_waitrequest;

`ifdef SYSID_CHECK_TIMEOUT_EN
    mega_jsoc_sysid_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .stalled (stalled),
        .expired (wait_expired)
    );
`else
    assign wait_expired = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Start is only honoured in IDLE, so requests during a sequence are dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RD_ID;
                end
            end
            RD_ID: begin
                if (wait_expired) begin
                    state_d = FINISH;
                end else if (rd_done) begin
                    state_d = RD_TS;
                end
            end
            RD_TS: begin
                if (wait_expired || rd_done) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            RD_ID, RD_TS: busy = 1'b1;
            FINISH:       done = 1'b1;
            default:      ;
        endcase
        pass = id_ok_q & ts_ok_q & ~timeout_q;
    end

    // The bus strobes follow the next state so the read starts with the state change
    // and stays frozen for as long as the state is held by waitrequest.
    always_comb begin
        av_read_d    = (state_d == RD_ID) || (state_d == RD_TS);
        av_address_d = (state_d == RD_TS) ? ADDR_TS : ADDR_ID;
        id_ok_d      = id_ok_q;
        ts_ok_d      = ts_ok_q;
        timeout_d    = timeout_q;
        id_value_d   = id_value_q;
        ts_value_d   = ts_value_q;

        if (state_q == IDLE && start) begin
            id_ok_d   = 1'b0;
            ts_ok_d   = 1'b0;
            timeout_d = 1'b0;
        end
        if (state_q == RD_ID && rd_done) begin
            id_value_d = av.av_readdata;
            id_ok_d    = (av.av_readdata == EXPECTED_ID);
        end
        if (state_q == RD_TS && rd_done) begin
            ts_value_d = av.av_readdata;
            ts_ok_d    = (av.av_readdata == EXPECTED_TIMESTAMP);
        end
        if (wait_expired) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            av_read_q    <= 1'b0;
            av_address_q <= ADDR_ID;
            id_ok_q      <= 1'b0;
            ts_ok_q      <= 1'b0;
            timeout_q    <= 1'b0;
            id_value_q   <= 32'd0;
            ts_value_q   <= 32'd0;
        end else begin
            av_read_q    <= av_read_d;
            av_address_q <= av_address_d;
            id_ok_q      <= id_ok_d;
            ts_ok_q      <= ts_ok_d;
            timeout_q    <= timeout_d;
            id_value_q   <= id_value_d;
            ts_value_q   <= ts_value_d;
        end
    end

    assign av.av_read    = av_read_q;
    assign av.av_address = av_address_q;
    assign id_ok         = id_ok_q;
    assign ts_ok         = ts_ok_q;
    assign timeout       = timeout_q;
    assign id_value      = id_value_q;
    assign ts_value      = ts_value_q;

endmodule

// File: tb/tb_mega_jsoc_sysid_checker.sv
// Self-checking bench for mega_jsoc_sysid_checker: reactive sysid responder, a
// sequence-level model checked every cycle, and directed literal checks.
module tb_mega_jsoc_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd30;
    localparam logic [31:0] EXP_TS = 32'd1718298719;
`ifdef SYSID_CHECK_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        pass;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    mega_jsoc_sysid_checker_if bus ();

    mega_jsoc_sysid_checker #(
        .EXPECTED_ID        (EXP_ID),
        .EXPECTED_TIMESTAMP (EXP_TS),
        .TIMEOUT_CYCLES     (TB_TIMEOUT)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .av       (bus),
        .busy     (busy),
        .done     (done),
        .id_ok    (id_ok),
        .ts_ok    (ts_ok),
        .pass     (pass),
        .timeout  (timeout),
        .id_value (id_value),
        .ts_value (ts_value)
    );

    initial forever #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Responder configuration, changed only while the checker is idle.
    int          cfg_wid   = 0;
    int          cfg_wts   = 0;
    bit          cfg_stuck = 1'b0;
    logic [31:0] cfg_id    = 32'd0;
    logic [31:0] cfg_ts    = 32'd0;

    // Sequence-level model: one outstanding sequence plus held results.
    bit          seq_active = 1'b0;
    int          seq_s      = 0;
    int          seq_wid    = 0;
    int          seq_wts    = 0;
    bit          seq_stuck  = 1'b0;
    logic        res_id_ok  = 1'b0;
    logic        res_ts_ok  = 1'b0;
    logic        res_to     = 1'b0;
    logic [31:0] res_idv    = 32'd0;
    logic [31:0] res_tsv    = 32'd0;
    logic [31:0] prev_idv   = 32'd0;
    logic [31:0] prev_tsv   = 32'd0;

    logic        snap_pass;
    logic        snap_id_ok;
    logic        snap_ts_ok;
    logic        snap_to;
    logic [31:0] snap_idv;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%08h, required 0x%08h",
                     name, cyc, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkOutput(name, {31'd0, actual}, {31'd0, expected});
    endtask

    task automatic nextCycle();
        @(negedge clock);
        #1;
    endtask

    function automatic int seqLast();
        return seq_stuck ? TB_TIMEOUT : 2 + seq_wid + seq_wts;
    endfunction

    function automatic bit modelIdle();
        return !seq_active || (cyc - seq_s > seqLast() + 1);
    endfunction

    task automatic modelReset();
        seq_active = 1'b0;
        res_id_ok  = 1'b0;
        res_ts_ok  = 1'b0;
        res_to     = 1'b0;
        res_idv    = 32'd0;
        res_tsv    = 32'd0;
        prev_idv   = 32'd0;
        prev_tsv   = 32'd0;
    endtask

    // Relative to the start cycle s: reads occupy s+1..s+last, done is at s+last+1.
    task automatic modelOutputs(output logic e_read, output logic e_addr, output logic e_busy,
                                output logic e_done, output logic e_idok, output logic e_tsok,
                                output logic e_to, output logic [31:0] e_idv,
                                output logic [31:0] e_tsv);
        int d;
        int last;
        bit id_read;
        d      = cyc - seq_s;
        last   = seqLast();
        e_read = 1'b0;
        e_addr = 1'b0;
        e_busy = 1'b0;
        e_done = 1'b0;
        e_idok = res_id_ok;
        e_tsok = res_ts_ok;
        e_to   = res_to;
        e_idv  = res_idv;
        e_tsv  = res_tsv;
        if (seq_active && d >= 1 && d <= last) begin
            id_read = !seq_stuck && (d >= 2 + seq_wid);
            e_read  = 1'b1;
            e_busy  = 1'b1;
            e_addr  = id_read;
            e_idok  = id_read ? res_id_ok : 1'b0;
            e_tsok  = 1'b0;
            e_to    = 1'b0;
            e_idv   = id_read ? res_idv : prev_idv;
            e_tsv   = prev_tsv;
        end else if (seq_active && d == last + 1) begin
            e_done = 1'b1;
        end
    endtask

    // Responder: stalls the configured number of cycles per word, junk data while stalled.
    initial begin
        int  stall_cnt;
        int  need;
        stall_cnt = 0;
        forever begin
            @(negedge clock);
            if (!bus.av_read) begin
                stall_cnt          = 0;
                bus.av_waitrequest = 1'b0;
                bus.av_readdata    = $urandom;
            end else begin
                need = cfg_stuck ? 32'h7fff_ffff : (bus.av_address ? cfg_wts : cfg_wid);
                if (stall_cnt < need) begin
                    stall_cnt++;
                    bus.av_waitrequest = 1'b1;
                    bus.av_readdata    = $urandom;
                end else begin
                    stall_cnt          = 0;
                    bus.av_waitrequest = 1'b0;
                    bus.av_readdata    = bus.av_address ? cfg_ts : cfg_id;
                end
            end
        end
    end

    // Every cycle, compare all DUT outputs against the model.
    initial begin
        logic        e_read, e_addr, e_busy, e_done, e_idok, e_tsok, e_to;
        logic [31:0] e_idv, e_tsv;
        forever begin
            @(negedge clock);
            modelOutputs(e_read, e_addr, e_busy, e_done, e_idok, e_tsok, e_to, e_idv, e_tsv);
            checkBit("av_read", bus.av_read, e_read);
            checkBit("av_address", bus.av_address, e_addr);
            checkBit("busy", busy, e_busy);
            checkBit("done", done, e_done);
            checkBit("id_ok", id_ok, e_idok);
            checkBit("ts_ok", ts_ok, e_tsok);
            checkBit("timeout", timeout, e_to);
            checkBit("pass", pass, e_idok & e_tsok & ~e_to);
            checkOutput("id_value", id_value, e_idv);
            checkOutput("ts_value", ts_value, e_tsv);
        end
    end

    task automatic applyStimulus(input int wid, input int wts, input logic [31:0] idw,
                                 input logic [31:0] tsw, input bit stuck);
        cfg_wid    = wid;
        cfg_wts    = wts;
        cfg_id     = idw;
        cfg_ts     = tsw;
        cfg_stuck  = stuck;
        prev_idv   = res_idv;
        prev_tsv   = res_tsv;
        seq_active = 1'b1;
        seq_s      = cyc;
        seq_wid    = wid;
        seq_wts    = wts;
        seq_stuck  = stuck;
        if (stuck) begin
            res_id_ok = 1'b0;
            res_ts_ok = 1'b0;
            res_to    = 1'b1;
        end else begin
            res_idv   = idw;
            res_tsv   = tsw;
            res_id_ok = (idw == EXP_ID);
            res_ts_ok = (tsw == EXP_TS);
            res_to    = 1'b0;
        end
        start = 1'b1;
        nextCycle();
        start = 1'b0;
    endtask

    // Runs the sequence to completion (bounded); mode 1 = random extra starts while
    // busy/finishing, mode 2 = extra starts at relative cycles 1, 2 and the FINISH cycle.
    task automatic waitSequence(input int mode, output int done_at, output int done_cnt);
        int limit;
        int d;
        done_at  = -1;
        done_cnt = 0;
        limit    = seq_s + seqLast() + 4;
        while (cyc <= limit) begin
            d = cyc - seq_s;
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at    = d;
                    snap_pass  = pass;
                    snap_id_ok = id_ok;
                    snap_ts_ok = ts_ok;
                    snap_to    = timeout;
                    snap_idv   = id_value;
                end
            end
            start = 1'b0;
            if (!modelIdle()) begin
                if (mode == 1 && $urandom_range(0, 2) == 0) start = 1'b1;
                if (mode == 2 && (d == 1 || d == 2 || d == seqLast() + 1)) start = 1'b1;
            end
            nextCycle();
        end
        start = 1'b0;
    endtask

    function automatic logic [31:0] randWord(input logic [31:0] good);
        case ($urandom_range(0, 3))
            0:       return good ^ (32'd1 << $urandom_range(0, 31));
            1:       return $urandom;
            default: return good;
        endcase
    endfunction

    initial begin
        int done_at;
        int done_cnt;
        start              = 1'b0;
        reset_n            = 1'b0;
        bus.av_readdata    = 32'd0;
        bus.av_waitrequest = 1'b0;
        modelReset();
        repeat (3) nextCycle();

        checkBit("reset_av_read", bus.av_read, 1'b0);
        checkBit("reset_busy", busy, 1'b0);
        checkBit("reset_pass", pass, 1'b0);
        checkOutput("reset_ts_value", ts_value, 32'd0);
        reset_n = 1'b1;
        nextCycle();

        $display("[TB] zero-wait sequence with matching words");
        applyStimulus(0, 0, EXP_ID, EXP_TS, 1'b0);
        waitSequence(0, done_at, done_cnt);
        checkOutput("zero_wait_latency", 32'(done_at), 32'd3);
        checkBit("zero_wait_pass", snap_pass, 1'b1);
        checkBit("zero_wait_id_ok", snap_id_ok, 1'b1);
        checkBit("zero_wait_ts_ok", snap_ts_ok, 1'b1);

        $display("[TB] wrong ID 31");
        applyStimulus(0, 0, 32'd31, EXP_TS, 1'b0);
        waitSequence(0, done_at, done_cnt);
        checkBit("bad_id_id_ok", snap_id_ok, 1'b0);
        checkBit("bad_id_ts_ok", snap_ts_ok, 1'b1);
        checkBit("bad_id_pass", snap_pass, 1'b0);
        checkOutput("bad_id_value", snap_idv, 32'd31);

        $display("[TB] five wait states per read");
        applyStimulus(5, 5, EXP_ID, EXP_TS, 1'b0);
        waitSequence(0, done_at, done_cnt);
        checkOutput("wait5_latency", 32'(done_at), 32'd13);
        checkBit("wait5_pass", snap_pass, 1'b1);

        $display("[TB] repeated start while busy and in FINISH");
        applyStimulus(0, 0, EXP_ID, EXP_TS ^ 32'h8000_0000, 1'b0);
        waitSequence(2, done_at, done_cnt);
        checkOutput("repeat_start_done_count", 32'(done_cnt), 32'd1);
        checkBit("msb_flip_ts_ok", snap_ts_ok, 1'b0);

        $display("[TB] reset asserted during the timestamp read");
        applyStimulus(0, 4, EXP_ID, EXP_TS, 1'b0);
        @(posedge clock);
        #1;
        checkBit("pre_reset_av_address", bus.av_address, 1'b1);
        checkBit("pre_reset_id_ok", id_ok, 1'b1);
        #1;
        reset_n = 1'b0;
        modelReset();
        #1;
        checkBit("mid_reset_av_read", bus.av_read, 1'b0);
        checkBit("mid_reset_busy", busy, 1'b0);
        checkBit("mid_reset_id_ok", id_ok, 1'b0);
        checkOutput("mid_reset_id_value", id_value, 32'd0);
        checkBit("mid_reset_done", done, 1'b0);
        nextCycle();
        nextCycle();
        reset_n  = 1'b1;
        done_cnt = 0;
        repeat (8) begin
            if (done) done_cnt++;
            nextCycle();
        end
        checkOutput("post_reset_done_count", 32'(done_cnt), 32'd0);

`ifdef SYSID_CHECK_TIMEOUT_EN
        $display("[TB] waitrequest stuck high with watchdog of 4");
        applyStimulus(0, 0, EXP_ID, EXP_TS, 1'b1);
        waitSequence(0, done_at, done_cnt);
        checkOutput("timeout_latency", 32'(done_at), 32'd5);
        checkBit("timeout_flag", snap_to, 1'b1);
        checkBit("timeout_pass", snap_pass, 1'b0);
`endif

        $display("[TB] randomized sequences");
        for (int i = 0; i < 40; i++) begin
            applyStimulus($urandom_range(0, 3), $urandom_range(0, 3),
                          randWord(EXP_ID), randWord(EXP_TS), 1'b0);
            waitSequence(1, done_at, done_cnt);
            checkOutput("random_done_count", 32'(done_cnt), 32'd1);
            repeat ($urandom_range(0, 2)) nextCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: bench did not reach its summary (errors so far %0d)", errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mega_jsoc_sysid_checker.md
MEGA_JSOC_SYSID_CHECKER -- requirements
Module: mega_jsoc_sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 30, is the system ID value the responder must return at word 0.
REQ-002 Parameter EXPECTED_TIMESTAMP, default 1718298719, is the build timestamp the responder must return at word 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, is the maximum number of waitrequest cycles per read; legal range 1..65535.
REQ-004 Port clock, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-005 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port start, input, 1 bit: single-cycle request to run one check sequence.
REQ-007 Port av_address, output, 1 bit: Avalon-MM word address (0 = ID, 1 = timestamp).
REQ-008 Port av_read, output, 1 bit: Avalon-MM read strobe.
REQ-009 Port av_readdata, input, 32 bits: read data from the sysid responder.
REQ-010 Port av_waitrequest, input, 1 bit: responder stall; a read completes on a cycle with av_read=1 and av_waitrequest=0.
REQ-011 Port busy, output, 1 bit: a sequence is in progress.
REQ-012 Port done, output, 1 bit: one-cycle pulse marking the end of a sequence.
REQ-013 Port id_ok / ts_ok, output, 1 bit each: the captured value equals the expected value.
REQ-014 Port pass, output, 1 bit: equals id_ok AND ts_ok AND NOT timeout.
REQ-015 Port timeout, output, 1 bit: the last sequence was aborted by the watchdog.
REQ-016 Port id_value / ts_value, output, 32 bits each: the last captured words.

Function
REQ-017 The FSM SHALL have the states IDLE, RD_ID, RD_TS and FINISH.
REQ-018 IDLE: start=1 SHALL go to RD_ID next cycle and clear id_ok, ts_ok, pass and timeout; busy=1 from that cycle on.
REQ-019 RD_ID: av_read=1 and av_address=0; on the completing cycle, latch av_readdata into id_value, set id_ok, then go to RD_TS.
REQ-020 RD_TS: av_read=1 and av_address=1; on the completing cycle, latch into ts_value, set ts_ok, then go to FINISH.
REQ-021 av_read and av_address SHALL be registered outputs, held stable while av_waitrequest=1.
REQ-022 av_read SHALL drop in the cycle after completion of RD_TS; there is no idle gap between the RD_ID and RD_TS reads.
REQ-023 FINISH: done=1 and pass valid for one cycle, busy=0, then return to IDLE.
REQ-024 Minimum latency with zero wait states: start to done SHALL be 3 cycles.
REQ-025 start while busy=1 or in FINISH SHALL be ignored and SHALL NOT be queued.
REQ-026 Result flags and values SHALL hold until the next accepted start.
REQ-027 Comparisons SHALL be full 32-bit equality with no masking.

Reset
REQ-028 While reset_n=0: state IDLE, av_read=0, av_address=0, busy=0, done=0, id_ok=0, ts_ok=0, pass=0, timeout=0, id_value=0, ts_value=0.
REQ-029 Reset mid-read SHALL drop av_read immediately and asynchronously; no done pulse is produced.

Configuration
REQ-030 With macro SYSID_CHECK_TIMEOUT_EN defined, a 16-bit wait counter SHALL:
- count consecutive av_waitrequest=1 cycles in RD_ID/RD_TS;
- reset on each completed read;
- on reaching TIMEOUT_CYCLES, set timeout=1, drop av_read and go to FINISH with pass=0.
REQ-031 Without SYSID_CHECK_TIMEOUT_EN, no counter is built, timeout is tied to 0, and the FSM SHALL wait indefinitely.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the word-address constants (ID=0, TS=1) and the default expected-value constants.
REQ-033 One sub-module, mega_jsoc_sysid_wait_timer (the counter plus terminal-count compare), SHALL be instantiated only under SYSID_CHECK_TIMEOUT_EN.

Verification
REQ-034 Zero-wait responder returning 30/1718298719, start pulse -> done at cycle 3, pass=1, id_ok=ts_ok=1.
REQ-035 Responder returning ID 31 -> id_ok=0, ts_ok=1, pass=0, id_value=31.
REQ-036 Waitrequest held 5 cycles on each read -> av_read and av_address stable throughout, done at cycle 13, pass=1.
REQ-037 Start repeated at cycles 1 and 2 while busy -> exactly one sequence and one done pulse.
REQ-038 reset_n pulsed low during RD_TS -> av_read=0 immediately, all outputs at reset values, no done pulse.
REQ-039 With SYSID_CHECK_TIMEOUT_EN and TIMEOUT_CYCLES=4, waitrequest stuck at 1 -> timeout=1, pass=0, done 4 cycles after the read is issued.
